// File: rtl/nexys_input_wb.sv
// Nexys switch/button input block on a 16-bit Wishbone bus: two-flop sync,
// per-bit debounce, sticky press latches with W1C, and a masked level interrupt.

module nexys_input_deb #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the debounced level throws away the partial count.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module nexys_input_wb #(
    parameter int NSW        = 8,
    parameter int NBTN       = 5,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      wb_adr_i,
    input  logic [15:0]     wb_dat_i,
    input  logic [1:0]      wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [15:0]     wb_dat_o,
    output logic            wb_ack_o,
    input  logic [NSW-1:0]  sw_i,
    input  logic [NBTN-1:0] btn_i,
    output logic            irq_o
);
    localparam int NB = NSW + NBTN;

    logic [NB-1:0]   raw, db;
    logic [NSW-1:0]  sw_db;
    logic [NBTN-1:0] btn_db, btn_q, pend, mask, mask_n, clr, rise;
    logic [15:0]     rd;
    logic            req, wr;
    logic            unused_ok;

    assign raw    = {btn_i, sw_i};
    assign sw_db  = db[NSW-1:0];
    assign btn_db = db[NB-1:NSW];

    generate
        for (genvar g = 0; g < NB; g++) begin : g_deb
            nexys_input_deb #(
                .DEB_CYCLES(DEB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_deb (
                .clk(clk_i),
                .rst(rst_i),
                .raw(raw[g]),
                .db (db[g])
            );
        end
    endgenerate

    assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr   = req & wb_we_i;
    assign rise = btn_db & ~btn_q;
    assign clr  = (wr && wb_adr_i == 2'd2 && wb_sel_i[0]) ? wb_dat_i[NBTN-1:0] : '0;
    assign unused_ok = ^{wb_dat_i, wb_sel_i};

    always_comb begin
        mask_n = mask;
        for (int i = 0; i < NBTN; i++) begin
            if (wb_sel_i[i/8]) mask_n[i] = wb_dat_i[i];
        end
    end

    always_comb begin
        rd = '0;
        case (wb_adr_i)
            2'd0: rd[NSW-1:0]  = sw_db;
            2'd1: rd[NBTN-1:0] = btn_db;
            2'd2: rd[NBTN-1:0] = pend;
            2'd3: rd[NBTN-1:0] = mask;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q    <= '0;
            pend     <= '0;
            mask     <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            btn_q    <= btn_db;
            // Set is applied after clear so a same-cycle press survives the W1C.
            pend     <= (pend & ~clr) | rise;
            if (wr && wb_adr_i == 2'd3) mask <= mask_n;
            wb_ack_o <= req;
            if (req) wb_dat_o <= rd;
            irq_o    <= |(pend & mask);
        end
    end
endmodule

// File: tb/tb_nexys_input_wb.sv
// Directed bench for nexys_input_wb with a short debounce window (DEB_CYCLES=4).

module tb_nexys_input_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_adr;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [15:0] wb_dat_o;
    logic        wb_ack;
    logic [7:0]  sw;
    logic [4:0]  btn;
    logic        irq;

    int vecs = 0;
    int errs = 0;
    logic [15:0] d;

    nexys_input_wb #(.NSW(8), .NBTN(5), .DEB_CYCLES(4), .CNT_W(16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel),
        .wb_we_i (wb_we),
        .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack),
        .sw_i    (sw),
        .btn_i   (btn),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb_rd(input string tag, input logic [1:0] adr, output logic [15:0] rdat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr; wb_sel = 2'b11;
        tick();
        chk({tag, "_ack"}, 16'(wb_ack), 16'h1);
        rdat = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();
    endtask

    task automatic wb_wr(input string tag, input logic [1:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_sel = sel;
        wb_dat_i = dat;
        tick();
        chk({tag, "_ack"}, 16'(wb_ack), 16'h1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; wb_adr = '0; wb_dat_i = '0; wb_sel = '0;
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; sw = 8'hFF; btn = '0;

        // 1: reset, then switch settle boundary (change lands on 6th edge)
        repeat (3) tick();
        chk("rst_ack", 16'(wb_ack), 16'h0);
        chk("rst_dat", wb_dat_o, 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        rst = 1'b0;
        wb_rd("sw_e1", 2'd0, d); chk("sw_e1", d, 16'h0000);
        wb_rd("sw_e3", 2'd0, d); chk("sw_e3", d, 16'h0000);
        wb_rd("sw_e5", 2'd0, d); chk("sw_e5", d, 16'h0000);
        wb_rd("sw_e7", 2'd0, d); chk("sw_e7", d, 16'h00FF);
        tick();
        chk("dat_hold", wb_dat_o, 16'h00FF);

        // 2: 3-cycle glitch is rejected
        btn[2] = 1'b1; repeat (3) tick(); btn[2] = 1'b0;
        repeat (10) tick();
        wb_rd("glt_btn", 2'd1, d); chk("glt_btn", d, 16'h0000);
        wb_rd("glt_pend", 2'd2, d); chk("glt_pend", d, 16'h0000);
        chk("glt_irq", 16'(irq), 16'h0);

        // 3: unmasked press
        wb_wr("mask_wr", 2'd3, 16'h0004, 2'b11);
        wb_rd("mask_rd", 2'd3, d); chk("mask_rd", d, 16'h0004);
        btn[2] = 1'b1;
        repeat (7) tick();
        chk("irq_pre", 16'(irq), 16'h0);
        tick();
        chk("irq_set", 16'(irq), 16'h1);
        repeat (2) tick();
        btn[2] = 1'b0;
        wb_rd("prs_btn", 2'd1, d); chk("prs_btn", d, 16'h0004);
        wb_rd("prs_pend", 2'd2, d); chk("prs_pend", d, 16'h0004);
        repeat (10) tick();
        wb_rd("rel_btn", 2'd1, d); chk("rel_btn", d, 16'h0000);
        wb_rd("rel_pend", 2'd2, d); chk("rel_pend", d, 16'h0004);

        // 4: W1C only through the low byte lane
        wb_wr("w1c_hi", 2'd2, 16'h0004, 2'b10);
        wb_rd("w1c_hi", 2'd2, d); chk("w1c_hi_pend", d, 16'h0004);
        chk("w1c_hi_irq", 16'(irq), 16'h1);
        wb_wr("w1c_lo", 2'd2, 16'h0004, 2'b01);
        chk("w1c_lo_irq", 16'(irq), 16'h0);
        wb_rd("w1c_lo", 2'd2, d); chk("w1c_lo_pend", d, 16'h0000);

        // 5: W1C on the set edge loses; read on the set edge sees old value
        btn[0] = 1'b1; repeat (6) tick();
        wb_wr("col_wr", 2'd2, 16'h0001, 2'b01);
        wb_rd("col_rd", 2'd2, d); chk("col_pend", d, 16'h0001);
        btn[1] = 1'b1; repeat (6) tick();
        wb_rd("pre_rd", 2'd2, d); chk("pre_pend", d, 16'h0001);
        wb_rd("post_rd", 2'd2, d); chk("post_pend", d, 16'h0003);
        chk("col_irq", 16'(irq), 16'h0);
        btn = '0; repeat (10) tick();

        // 6: held strobe acks every other cycle; SW is read-only
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ack_pat%0d", i), 16'(wb_ack), 16'(i % 2));
            tick();
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();
        chk("ack_drop", 16'(wb_ack), 16'h0);
        wb_wr("sw_wr", 2'd0, 16'h0000, 2'b11);
        wb_rd("sw_ro", 2'd0, d); chk("sw_ro", d, 16'h00FF);

        wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        chk("rst_mid_ack1", 16'(wb_ack), 16'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_ack0", 16'(wb_ack), 16'h0);
        chk("rst_mid_dat", wb_dat_o, 16'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
